// File: rtl/mem_addr_sequencer_if.sv
// Bus bundle for the memory-address sequencer: source operands,
// exception requests and the registered address/vector-fetch results.
interface mem_addr_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_EXC = 3
);
  localparam int CW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;

  logic [2:0]         sel;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  a_imm;
  logic [ADDR_W-1:0]  alu_out;
  logic [NUM_EXC-1:0] exc_req;
  logic [7:0]         mem_rdata;
  logic [ADDR_W-1:0]  addr;
  logic               exc_busy;
  logic [ADDR_W-1:0]  epc;
  logic [CW-1:0]      cause;
  logic [ADDR_W-1:0]  handler_pc;
  logic               handler_valid;
  logic               sel_err;

  modport master (
    output sel, pc, a_imm, alu_out, exc_req, mem_rdata,
    input  addr, exc_busy, epc, cause,
    input  handler_pc, handler_valid, sel_err
  );

  modport slave (
    input  sel, pc, a_imm, alu_out, exc_req, mem_rdata,
    output addr, exc_busy, epc, cause,
    output handler_pc, handler_valid, sel_err
  );
endinterface

// File: rtl/mem_addr_sequencer.sv
// Registered memory-address mux with an exception-vector fetch
// sequencer that returns the handler byte as the new PC.
module mem_addr_sequencer #(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_EXC  = 3,
  parameter logic [31:0] VEC_BASE = 32'h253,
  parameter int          MEM_LAT  = 1
) (
  input logic            clk,
  input logic            reset_n,
  mem_addr_sequencer_if.slave bus
);
  localparam int CW    = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W-1:0] VB = ADDR_W'(VEC_BASE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEC_WAIT,
    S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [ADDR_W-1:0] r_epc, w_epc;
  logic [CW-1:0]     r_cause, w_cause;
  logic [ADDR_W-1:0] r_hpc, w_hpc;
  logic              r_hv, w_hv;
  logic              r_busy, w_busy;
  logic              r_sel_err, w_sel_err;

  logic [CW-1:0]     w_idx;
  logic              w_any;
  logic [ADDR_W-1:0] w_src;
  logic              w_bad;

  // Lowest set request bit wins
  always_comb begin
    w_idx = '0;
    w_any = |bus.exc_req;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (bus.exc_req[i]) w_idx = CW'(i);
    end
  end

  always_comb begin
    w_src = r_addr;
    w_bad = 1'b0;
    unique case (bus.sel)
      3'd0:    w_src = bus.pc;
      3'd1:    w_src = bus.a_imm;
      3'd2:    w_src = VB;
      3'd3:    w_src = VB + ADDR_W'(1);
      3'd4:    w_src = VB + ADDR_W'(2);
      3'd5:    w_src = bus.alu_out;
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_addr    = r_addr;
    w_epc     = r_epc;
    w_cause   = r_cause;
    w_hpc     = r_hpc;
    w_hv      = 1'b0;
    w_busy    = r_busy;
    w_sel_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_addr  = VB + ADDR_W'(w_idx);
          w_epc   = bus.pc;
          w_cause = w_idx;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_state = S_VEC_WAIT;
        end else begin
          w_addr    = w_src;
          w_sel_err = w_bad;
        end
      end
      S_VEC_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_hpc   = ADDR_W'(bus.mem_rdata);
          w_hv    = 1'b1;
          w_busy  = 1'b0;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_addr    = w_src;
        w_sel_err = w_bad;
        w_state   = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_epc     <= '0;
      r_cause   <= '0;
      r_hpc     <= '0;
      r_hv      <= 1'b0;
      r_busy    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_addr    <= w_addr;
      r_epc     <= w_epc;
      r_cause   <= w_cause;
      r_hpc     <= w_hpc;
      r_hv      <= w_hv;
      r_busy    <= w_busy;
      r_sel_err <= w_sel_err;
    end
  end

  assign bus.addr          = r_addr;
  assign bus.exc_busy      = r_busy;
  assign bus.epc           = r_epc;
  assign bus.cause         = r_cause;
  assign bus.handler_pc    = r_hpc;
  assign bus.handler_valid = r_hv;
  assign bus.sel_err       = r_sel_err;
endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Scoreboard bench: two sequencers (MEM_LAT 1 and 3) driven with
// directed vectors, checked by a cycle-indexed monitor.
module tb_mem_addr_sequencer;
  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] val;
    string       nm;
  } chk_t;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } hexp_t;

  localparam int F_ADDR = 0;
  localparam int F_EPC  = 1;
  localparam int F_CAU  = 2;
  localparam int F_HPC  = 3;
  localparam int F_HV   = 4;
  localparam int F_BUSY = 5;
  localparam int F_SERR = 6;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  chk_t  q[$];
  hexp_t hq0[$];
  hexp_t hq1[$];

  mem_addr_sequencer_if #(.ADDR_W(32), .NUM_EXC(3)) b0 ();
  mem_addr_sequencer_if #(.ADDR_W(32), .NUM_EXC(3)) b1 ();

  mem_addr_sequencer #(
    .ADDR_W(32), .NUM_EXC(3), .VEC_BASE(32'h253), .MEM_LAT(1)
  ) u0 (
    .clk(clk), .reset_n(rst0_n), .bus(b0)
  );

  mem_addr_sequencer #(
    .ADDR_W(32), .NUM_EXC(3), .VEC_BASE(32'h253), .MEM_LAT(3)
  ) u1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get(input int d, input int f);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (f)
        F_ADDR: v = b0.addr;
        F_EPC:  v = b0.epc;
        F_CAU:  v = 32'(b0.cause);
        F_HPC:  v = b0.handler_pc;
        F_HV:   v = 32'(b0.handler_valid);
        F_BUSY: v = 32'(b0.exc_busy);
        default: v = 32'(b0.sel_err);
      endcase
    end else begin
      case (f)
        F_ADDR: v = b1.addr;
        F_EPC:  v = b1.epc;
        F_CAU:  v = 32'(b1.cause);
        F_HPC:  v = b1.handler_pc;
        F_HV:   v = 32'(b1.handler_valid);
        F_BUSY: v = 32'(b1.exc_busy);
        default: v = 32'(b1.sel_err);
      endcase
    end
    return v;
  endfunction

  // Monitor: runs 1ns after every rising edge
  initial begin
    chk_t  keep[$];
    hexp_t h;
    logic [31:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      keep = {};
      foreach (q[j]) begin
        if (q[j].cyc == cyc) begin
          got = get(q[j].dut, q[j].fld);
          n_cmp++;
          if (got !== q[j].val) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     q[j].nm, cyc, got, q[j].val);
          end
        end else begin
          keep.push_back(q[j]);
        end
      end
      q = keep;
      if (b0.handler_valid) begin
        n_cmp++;
        if (hq0.size() == 0) begin
          n_bad++;
          $display("FAIL hv0_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          h = hq0.pop_front();
          if (h.cyc != cyc || b0.handler_pc !== h.val) begin
            n_bad++;
            $display("FAIL hv0_pulse cyc=%0d got=%0h@%0d exp=%0h@%0d",
                     cyc, b0.handler_pc, cyc, h.val, h.cyc);
          end
        end
      end
      if (b1.handler_valid) begin
        n_cmp++;
        if (hq1.size() == 0) begin
          n_bad++;
          $display("FAIL hv1_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          h = hq1.pop_front();
          if (h.cyc != cyc || b1.handler_pc !== h.val) begin
            n_bad++;
            $display("FAIL hv1_pulse cyc=%0d got=%0h@%0d exp=%0h@%0d",
                     cyc, b1.handler_pc, cyc, h.val, h.cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected value visible after the next rising edge
  task automatic ex(input int d, input int f,
                    input logic [31:0] v, input string nm);
    chk_t c;
    c.cyc = cyc + 1;
    c.dut = d;
    c.fld = f;
    c.val = v;
    c.nm  = nm;
    q.push_back(c);
  endtask

  task automatic hx(input int d, input logic [31:0] v);
    hexp_t h;
    h.cyc = cyc + 1;
    h.val = v;
    if (d == 0) hq0.push_back(h);
    else hq1.push_back(h);
  endtask

  task automatic ex_reset(input int d, input string nm);
    ex(d, F_ADDR, 32'h0, {nm, "_addr"});
    ex(d, F_EPC,  32'h0, {nm, "_epc"});
    ex(d, F_CAU,  32'h0, {nm, "_cause"});
    ex(d, F_HPC,  32'h0, {nm, "_hpc"});
    ex(d, F_HV,   32'h0, {nm, "_hv"});
    ex(d, F_BUSY, 32'h0, {nm, "_busy"});
    ex(d, F_SERR, 32'h0, {nm, "_serr"});
  endtask

  initial begin
    b0.sel = 3'd0; b0.pc = '0; b0.a_imm = '0; b0.alu_out = '0;
    b0.exc_req = '0; b0.mem_rdata = '0;
    b1.sel = 3'd0; b1.pc = '0; b1.a_imm = '0; b1.alu_out = '0;
    b1.exc_req = '0; b1.mem_rdata = '0;

    // ---- DUT0, MEM_LAT = 1 ----
    step();
    ex_reset(0, "rst0");
    step();
    rst0_n = 1'b1;
    b0.sel = 3'd0; b0.pc = 32'h40;
    ex(0, F_ADDR, 32'h40, "sel_pc");
    step();
    b0.sel = 3'd5; b0.alu_out = 32'h1234;
    ex(0, F_ADDR, 32'h1234, "sel_alu");
    step();
    b0.exc_req = 3'b010; b0.pc = 32'h88; b0.sel = 3'd0;
    b0.mem_rdata = 8'h11;
    ex(0, F_ADDR, 32'h254, "exc1_addr");
    ex(0, F_EPC,  32'h88,  "exc1_epc");
    ex(0, F_CAU,  32'h1,   "exc1_cause");
    ex(0, F_BUSY, 32'h1,   "exc1_busy");
    step();
    b0.exc_req = '0; b0.mem_rdata = 8'h7C;
    hx(0, 32'h7C);
    ex(0, F_BUSY, 32'h0,   "exc1_busy_off");
    ex(0, F_ADDR, 32'h254, "exc1_addr_hold");
    step();
    b0.sel = 3'd1; b0.a_imm = 32'h10; b0.mem_rdata = 8'h99;
    ex(0, F_ADDR, 32'h10, "done_sel");
    ex(0, F_HV,   32'h0,  "done_hv_off");
    ex(0, F_EPC,  32'h88, "done_epc");
    ex(0, F_HPC,  32'h7C, "done_hpc");
    step();
    b0.exc_req = 3'b110; b0.pc = 32'h100;
    ex(0, F_ADDR, 32'h254, "exc2_addr");
    ex(0, F_EPC,  32'h100, "exc2_epc");
    ex(0, F_CAU,  32'h1,   "exc2_cause");
    ex(0, F_BUSY, 32'h1,   "exc2_busy");
    step();
    b0.exc_req = 3'b001; b0.pc = 32'h200; b0.mem_rdata = 8'h55;
    hx(0, 32'h55);
    ex(0, F_ADDR, 32'h254, "drop_addr");
    ex(0, F_BUSY, 32'h0,   "drop_busy");
    ex(0, F_EPC,  32'h100, "drop_epc");
    ex(0, F_CAU,  32'h1,   "drop_cause");
    step();
    b0.exc_req = '0; b0.sel = 3'd0; b0.pc = 32'h40;
    ex(0, F_ADDR, 32'h40,  "post_addr");
    ex(0, F_EPC,  32'h100, "post_epc");
    ex(0, F_CAU,  32'h1,   "post_cause");
    step();
    b0.sel = 3'd6;
    ex(0, F_ADDR, 32'h40, "sel6_addr");
    ex(0, F_SERR, 32'h1,  "sel6_err");
    step();
    b0.sel = 3'd3;
    ex(0, F_ADDR, 32'h254, "sel3_addr");
    ex(0, F_SERR, 32'h0,   "sel3_err");
    ex(0, F_EPC,  32'h100, "sel3_epc");
    ex(0, F_BUSY, 32'h0,   "sel3_busy");
    step();
    b0.sel = 3'd7;
    ex(0, F_ADDR, 32'h254, "sel7_addr");
    ex(0, F_SERR, 32'h1,   "sel7_err");
    step();
    b0.sel = 3'd2;
    ex(0, F_ADDR, 32'h253, "sel2_addr");
    step();
    b0.sel = 3'd4;
    ex(0, F_ADDR, 32'h255, "sel4_addr");
    ex(0, F_SERR, 32'h0,   "sel4_err");
    step();
    b0.sel = 3'd0;

    // ---- DUT1, MEM_LAT = 3 ----
    ex_reset(1, "rst1");
    step();
    rst1_n = 1'b1;
    b1.sel = 3'd0; b1.pc = 32'h300;
    ex(1, F_ADDR, 32'h300, "l3_sel_pc");
    step();
    b1.exc_req = 3'b100; b1.mem_rdata = 8'h01;
    ex(1, F_ADDR, 32'h255, "l3_addr0");
    ex(1, F_EPC,  32'h300, "l3_epc");
    ex(1, F_CAU,  32'h2,   "l3_cause");
    ex(1, F_BUSY, 32'h1,   "l3_busy0");
    step();
    b1.exc_req = '0; b1.mem_rdata = 8'h02;
    ex(1, F_ADDR, 32'h255, "l3_addr1");
    ex(1, F_BUSY, 32'h1,   "l3_busy1");
    step();
    b1.mem_rdata = 8'h03;
    ex(1, F_ADDR, 32'h255, "l3_addr2");
    ex(1, F_BUSY, 32'h1,   "l3_busy2");
    step();
    b1.mem_rdata = 8'hA5;
    hx(1, 32'hA5);
    ex(1, F_BUSY, 32'h0, "l3_busy3");
    step();
    b1.mem_rdata = 8'h00; b1.sel = 3'd1; b1.a_imm = 32'h20;
    ex(1, F_ADDR, 32'h20, "l3_done_sel");
    ex(1, F_HPC,  32'hA5, "l3_hpc_hold");
    step();
    b1.exc_req = 3'b001; b1.pc = 32'h400; b1.mem_rdata = 8'h66;
    ex(1, F_ADDR, 32'h253, "abort_addr");
    ex(1, F_BUSY, 32'h1,   "abort_busy");
    step();
    b1.exc_req = '0;
    rst1_n = 1'b0;
    ex_reset(1, "abort_rst");
    step();
    rst1_n = 1'b1;
    b1.sel = 3'd1; b1.a_imm = 32'h10;
    ex(1, F_ADDR, 32'h10, "abort_sel");
    ex(1, F_BUSY, 32'h0,  "abort_busy_off");
    repeat (5) step();

    foreach (q[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never_checked got=none exp=%0h", q[j].nm, q[j].val);
    end
    foreach (hq0[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hv0_missing got=none exp=%0h@%0d", hq0[j].val, hq0[j].cyc);
    end
    foreach (hq1[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hv1_missing got=none exp=%0h@%0d", hq1[j].val, hq1[j].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
